// File: rtl/pulse_generation.sv
// Heartbeat transmitter: a fixed-period, 50 % duty PWM line with self-test modes
// that stretch the period, widen the high phase, or hold the line silent.
module pulse_generation #(
  parameter int PERIOD = 14746,
  parameter int SKEW   = 100
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] fault_mode,
  output logic       pwm,
  output logic       active,
  output logic       period_tick
);

  localparam logic [15:0] P_NORM = 16'(PERIOD);
  localparam logic [15:0] P_LONG = 16'(PERIOD + SKEW);
  localparam logic [15:0] H_NORM = 16'(PERIOD / 2);
  localparam logic [15:0] H_WIDE = 16'(PERIOD / 2 + SKEW);

  localparam logic [1:0] MODE_LONG   = 2'b01;
  localparam logic [1:0] MODE_WIDE   = 2'b10;
  localparam logic [1:0] MODE_SILENT = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    SILENT
  } state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [1:0]  mode_q, mode_d;
  logic        start;
  logic        pwm_d, active_d, tick_d;

  function automatic logic [15:0] period_of(input logic [1:0] mode);
    return (mode == MODE_LONG) ? P_LONG : P_NORM;
  endfunction

  function automatic logic [15:0] high_of(input logic [1:0] mode);
    return (mode == MODE_WIDE) ? H_WIDE : H_NORM;
  endfunction

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves one unassigned (no latch).
    state_d = state;
    cnt_d   = cnt;
    mode_d  = mode_q;
    start   = 1'b0;

    unique case (state)
      IDLE: start = en;
      RUN, SILENT: begin
        if (cnt == period_of(mode_q) - 16'd1) begin
          if (en) begin
            start = 1'b1;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // A period boundary is the only point where the fault mode is sampled.
    if (start) begin
      cnt_d   = '0;
      mode_d  = fault_mode;
      state_d = (fault_mode == MODE_SILENT) ? SILENT : RUN;
    end

    // Outputs are decoded from the next-state values so they can be registered
    // without adding a cycle of latency relative to the counter.
    pwm_d    = (state_d == RUN) && (cnt_d < high_of(mode_d));
    active_d = (state_d != IDLE);
    tick_d   = (state_d == RUN) && (cnt_d == '0);
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      mode_q      <= '0;
      pwm         <= 1'b0;
      active      <= 1'b0;
      period_tick <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      mode_q      <= mode_d;
      pwm         <= pwm_d;
      active      <= active_d;
      period_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_pulse_generation.sv
// Directed bench for pulse_generation, run with a shortened period so every
// mode transition fits in a few hundred cycles.
module tb_pulse_generation;

  localparam int PERIOD = 40;
  localparam int SKEW   = 6;
  localparam int H      = PERIOD / 2;   // 20
  localparam int P_LONG = PERIOD + SKEW; // 46
  localparam int H_WIDE = H + SKEW;      // 26

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] fault_mode = 2'b00;
  logic       pwm, active, period_tick;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int tick_bad = 0;
  int rises[$];
  int falls[$];
  int act_falls[$];
  logic pwm_prev = 1'b0;
  logic act_prev = 1'b0;
  int r0;

  pulse_generation #(.PERIOD(PERIOD), .SKEW(SKEW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .fault_mode (fault_mode),
    .pwm        (pwm),
    .active     (active),
    .period_tick(period_tick)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Edge recorder plus continuous tick/active consistency check.
  always @(negedge clk) begin
    if (pwm && !pwm_prev) rises.push_back(cyc);
    if (!pwm && pwm_prev) falls.push_back(cyc);
    if (!active && act_prev) act_falls.push_back(cyc);
    if (rst_n && (period_tick != (pwm && !pwm_prev))) tick_bad++;
    if (pwm && !active) tick_bad++;
    pwm_prev = pwm;
    act_prev = active;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    rises.delete();
    falls.delete();
    act_falls.delete();
  endtask

  function automatic int rise_at(input int i);
    return (i < rises.size()) ? rises[i] : -100000;
  endfunction

  function automatic int high_after(input int r);
    foreach (falls[i]) if (falls[i] > r) return falls[i] - r;
    return -1;
  endfunction

  task automatic wait_tick(input string tag, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      #1;
      if (period_tick) seen = 1'b1;
    end
    if (!seen) check({tag, "_tick_timeout"}, 0, 1);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst_pwm", pwm, 0);
    check("rst_active", active, 0);
    check("rst_tick", period_tick, 0);

    // 1: enable in normal mode, one-cycle latency, period and high time
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1 check("idle_active", active, 0);
    @(negedge clk) en = 1'b1;
    #1 clear_log();
    @(posedge clk);
    #1;
    check("t1_pwm_latency", pwm, 1);
    check("t1_tick_latency", period_tick, 1);
    check("t1_active", active, 1);
    repeat (130) @(negedge clk);
    #1;
    check("t1_rises", rises.size(), 4);
    check("t1_period0", rise_at(1) - rise_at(0), PERIOD);
    check("t1_period1", rise_at(3) - rise_at(2), PERIOD);
    check("t1_high0", high_after(rise_at(0)), H);
    check("t1_high2", high_after(rise_at(2)), H);

    // 2: disable mid-period, period completes then IDLE
    clear_log();
    wait_tick("t2", 2 * PERIOD);
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (80) @(negedge clk);
    #1;
    check("t2_rises", rises.size(), 1);
    check("t2_high", high_after(rise_at(0)), H);
    check("t2_act_falls", act_falls.size(), 1);
    check("t2_active_span", (act_falls.size() > 0) ? act_falls[0] - rise_at(0) : -1, PERIOD);
    check("t2_pwm_idle", pwm, 0);
    check("t2_active_idle", active, 0);

    // 3: mode 01 set mid-period only takes effect at the next boundary
    @(negedge clk) en = 1'b1;
    #1 clear_log();
    wait_tick("t3", 4);
    repeat (10) @(negedge clk);
    fault_mode = 2'b01;
    repeat (140) @(negedge clk);
    #1;
    check("t3_period_cur", rise_at(1) - rise_at(0), PERIOD);
    check("t3_period_long1", rise_at(2) - rise_at(1), P_LONG);
    check("t3_period_long2", rise_at(3) - rise_at(2), P_LONG);
    check("t3_high_long", high_after(rise_at(1)), H);

    // 4: mode 10 widens the high phase, back to 00 restores it
    clear_log();
    wait_tick("t4a", 2 * P_LONG);
    repeat (3) @(negedge clk);
    fault_mode = 2'b10;
    wait_tick("t4b", 2 * P_LONG);
    repeat (3) @(negedge clk);
    fault_mode = 2'b00;
    wait_tick("t4c", 2 * P_LONG);
    repeat (45) @(negedge clk);
    #1;
    check("t4_period_a", rise_at(1) - rise_at(0), P_LONG);
    check("t4_high_wide", high_after(rise_at(1)), H_WIDE);
    check("t4_period_wide", rise_at(2) - rise_at(1), PERIOD);
    check("t4_high_norm", high_after(rise_at(2)), H);

    // 5: silent period, then return to normal exactly one period later
    clear_log();
    wait_tick("t5a", 2 * PERIOD);
    repeat (3) @(negedge clk);
    fault_mode = 2'b11;
    repeat (PERIOD - 3) @(negedge clk);
    #1;
    check("t5_silent_pwm", pwm, 0);
    check("t5_silent_active", active, 1);
    check("t5_silent_tick", period_tick, 0);
    fault_mode = 2'b00;
    wait_tick("t5b", 3 * PERIOD);
    check("t5_rises", rises.size(), 2);
    check("t5_gap", rise_at(1) - rise_at(0), 2 * PERIOD);

    // 6: asynchronous reset mid high phase, fresh period after release
    clear_log();
    wait_tick("t6", 2 * PERIOD);
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_pwm", pwm, 0);
    check("t6_async_active", active, 0);
    repeat (3) @(negedge clk);
    #1 clear_log();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("t6_restart_pwm", pwm, 1);
    check("t6_restart_tick", period_tick, 1);
    repeat (45) @(negedge clk);
    #1;
    check("t6_period", rise_at(1) - rise_at(0), PERIOD);
    check("t6_high", high_after(rise_at(0)), H);

    check("tick_consistency", tick_bad, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
